// File: rtl/memory_controller_wait.sv
// MAR/MDR memory interface with a wait-state read/write handshake toward synchronous SRAM.
// Strobes low for WAIT_STATES cycles, Ready pulses one cycle later; requests outside IDLE are dropped.
module memory_controller_wait #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic [DATA_W-1:0] bus,
  input  logic [DATA_W-1:0] Mem_Data_In,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data_Out,
  output logic              Mem_CE_n,
  output logic              Mem_OE_n,
  output logic              Mem_WE_n,
  output logic              Ready,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              ce_n_q, oe_n_q, we_n_q, ready_q, busy_q;

  // Narrow MAR keeps the low bus bits; a wide MAR zero-extends the bus.
  generate
    if (ADDR_W <= DATA_W) begin : g_mar_trunc
      assign mar_d = bus[ADDR_W-1:0];
    end else begin : g_mar_zext
      assign mar_d = {{(ADDR_W-DATA_W){1'b0}}, bus};
    end
  endgenerate

  assign mdr_d = MIO_EN ? Mem_Data_In : bus;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (LD_MAR) mar_q <= mar_d;
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (LD_MDR) mdr_q <= mdr_d;
          // Captures use pre-edge MAR/MDR, so same-cycle loads do not leak into the access.
          if (Mem_Read) begin
            addr_q  <= mar_q;
            cnt_q   <= WS_M1;
            state_q <= RD;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (Mem_Write) begin
            addr_q  <= mar_q;
            dout_q  <= mdr_q;
            cnt_q   <= WS_M1;
            state_q <= WR;
            ce_n_q  <= 1'b0;
            we_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RD: begin
          if (cnt_q == 4'd0) begin
            mdr_q   <= Mem_Data_In;
            state_q <= DONE;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MAR          = mar_q;
  assign MDR          = mdr_q;
  assign Mem_Addr     = addr_q;
  assign Mem_Data_Out = dout_q;
  assign Mem_CE_n     = ce_n_q;
  assign Mem_OE_n     = oe_n_q;
  assign Mem_WE_n     = we_n_q;
  assign Ready        = ready_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_memory_controller_wait.sv
// Directed bench: cycle table against a WAIT_STATES=2 instance, then wait-state/width sweeps.
module tb_memory_controller_wait;

  logic        Clk = 1'b0;
  logic        Reset_n, LD_MAR, LD_MDR, MIO_EN, Mem_Read, Mem_Write;
  logic [15:0] bus, Mem_Data_In;

  always #5 Clk = ~Clk;

  logic [15:0] mar2, mdr2, addr2, dout2;
  logic        ce2, oe2, we2, rdy2, bsy2;
  logic [19:0] mar1, addr1;
  logic [15:0] mdr1, dout1;
  logic        ce1, oe1, we1, rdy1, bsy1;
  logic [15:0] mar15, mdr15, addr15, dout15;
  logic        ce15, oe15, we15, rdy15, bsy15;

  memory_controller_wait #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(2)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .bus(bus), .Mem_Data_In(Mem_Data_In),
    .MAR(mar2), .MDR(mdr2), .Mem_Addr(addr2), .Mem_Data_Out(dout2),
    .Mem_CE_n(ce2), .Mem_OE_n(oe2), .Mem_WE_n(we2), .Ready(rdy2), .Busy(bsy2));

  memory_controller_wait #(.DATA_W(16), .ADDR_W(20), .WAIT_STATES(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .bus(bus), .Mem_Data_In(Mem_Data_In),
    .MAR(mar1), .MDR(mdr1), .Mem_Addr(addr1), .Mem_Data_Out(dout1),
    .Mem_CE_n(ce1), .Mem_OE_n(oe1), .Mem_WE_n(we1), .Ready(rdy1), .Busy(bsy1));

  memory_controller_wait #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(15)) dut15 (
    .Clk(Clk), .Reset_n(Reset_n), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .bus(bus), .Mem_Data_In(Mem_Data_In),
    .MAR(mar15), .MDR(mdr15), .Mem_Addr(addr15), .Mem_Data_Out(dout15),
    .Mem_CE_n(ce15), .Mem_OE_n(oe15), .Mem_WE_n(we15), .Ready(rdy15), .Busy(bsy15));

  typedef struct {
    string       name;
    logic [5:0]  ctl;   // {Reset_n, LD_MAR, LD_MDR, MIO_EN, Mem_Read, Mem_Write}
    logic [15:0] bus;
    logic [15:0] din;
    logic [15:0] mar, mdr, addr, dout;
    logic [4:0]  st;    // {CE_n, OE_n, WE_n, Ready, Busy}
  } vec_t;

  localparam logic [4:0] S_IDLE = 5'b111_0_0;
  localparam logic [4:0] S_RD   = 5'b001_0_1;
  localparam logic [4:0] S_WR   = 5'b010_0_1;
  localparam logic [4:0] S_DONE = 5'b111_1_1;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input string n, input logic [5:0] c, input logic [15:0] b, input logic [15:0] d,
                     input logic [15:0] mar, input logic [15:0] mdr, input logic [15:0] addr,
                     input logic [15:0] dout, input logic [4:0] st);
    vec_t v;
    v.name = n; v.ctl = c; v.bus = b; v.din = d;
    v.mar = mar; v.mdr = mdr; v.addr = addr; v.dout = dout; v.st = st;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  int          w1, w15;
  bit          run1, run15;
  int          r1[$], r15[$];
  logic [2:0]  st1_c1;

  initial begin
    Reset_n = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0;
    Mem_Read = 1'b0; Mem_Write = 1'b0; bus = '0; Mem_Data_In = '0;

    //   name          ctl        bus      din      MAR      MDR      Addr     DataOut  strobes
    add("rst0",       6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, S_IDLE);
    add("rst1",       6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, S_IDLE);
    add("idle",       6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, S_IDLE);
    add("ld_mar",     6'b110000, 16'h3000, 16'h0000, 16'h3000, 16'h0000, 16'h0000, 16'h0000, S_IDLE);
    add("rd_c1",      6'b100010, 16'h0000, 16'hBEEF, 16'h3000, 16'h0000, 16'h3000, 16'h0000, S_RD);
    add("rd_c2",      6'b100000, 16'h0000, 16'hBEEF, 16'h3000, 16'h0000, 16'h3000, 16'h0000, S_RD);
    add("rd_done",    6'b100000, 16'h0000, 16'hBEEF, 16'h3000, 16'hBEEF, 16'h3000, 16'h0000, S_DONE);
    add("rd_idle",    6'b100000, 16'h0000, 16'hBEEF, 16'h3000, 16'hBEEF, 16'h3000, 16'h0000, S_IDLE);
    add("ld_mar2",    6'b110000, 16'h4001, 16'h0000, 16'h4001, 16'hBEEF, 16'h3000, 16'h0000, S_IDLE);
    add("ld_mdr_bus", 6'b101000, 16'h1234, 16'h0000, 16'h4001, 16'h1234, 16'h3000, 16'h0000, S_IDLE);
    add("wr_c1",      6'b100001, 16'h0000, 16'h0000, 16'h4001, 16'h1234, 16'h4001, 16'h1234, S_WR);
    add("wr_c2",      6'b100000, 16'h0000, 16'h0000, 16'h4001, 16'h1234, 16'h4001, 16'h1234, S_WR);
    add("wr_done",    6'b100000, 16'h0000, 16'h0000, 16'h4001, 16'h1234, 16'h4001, 16'h1234, S_DONE);
    add("wr_idle",    6'b100000, 16'h0000, 16'h0000, 16'h4001, 16'h1234, 16'h4001, 16'h1234, S_IDLE);
    add("rw_both",    6'b110011, 16'h5000, 16'h7777, 16'h5000, 16'h1234, 16'h4001, 16'h1234, S_RD);
    add("rd_ignore",  6'b111001, 16'h5555, 16'h7777, 16'h5555, 16'h1234, 16'h4001, 16'h1234, S_RD);
    add("rd_done2",   6'b101000, 16'hAAAA, 16'h7777, 16'h5555, 16'h7777, 16'h4001, 16'h1234, S_DONE);
    add("done_ign",   6'b100001, 16'h0000, 16'h7777, 16'h5555, 16'h7777, 16'h4001, 16'h1234, S_IDLE);
    add("ld_mdr_mem", 6'b101100, 16'h0000, 16'h5A5A, 16'h5555, 16'h5A5A, 16'h4001, 16'h1234, S_IDLE);
    add("rd_abort",   6'b100010, 16'h0000, 16'h0000, 16'h5555, 16'h5A5A, 16'h5555, 16'h1234, S_RD);
    add("rst_mid",    6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, S_IDLE);
    add("post_rst",   6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, S_IDLE);
    add("no_ready",   6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, S_IDLE);

    for (int i = 0; i < tv.size(); i++) begin
      {Reset_n, LD_MAR, LD_MDR, MIO_EN, Mem_Read, Mem_Write} = tv[i].ctl;
      bus = tv[i].bus;
      Mem_Data_In = tv[i].din;
      cycle();
      chk(tv[i].name,
          80'({mar2, mdr2, addr2, dout2, ce2, oe2, we2, rdy2, bsy2}),
          80'({tv[i].mar, tv[i].mdr, tv[i].addr, tv[i].dout, tv[i].st}));
    end

    // Wait-state sweep and wide-MAR check on the WAIT_STATES=1 and 15 instances.
    {Reset_n, LD_MAR, LD_MDR, MIO_EN, Mem_Read, Mem_Write} = 6'b000000;
    bus = '0; Mem_Data_In = '0;
    cycle(); cycle();
    Reset_n = 1'b1; LD_MAR = 1'b1; bus = 16'hABCD;
    cycle();
    LD_MAR = 1'b0; bus = '0;
    chk("ws1_mar_zext", 80'(mar1), 80'(20'h0ABCD));
    chk("ws15_mar", 80'(mar15), 80'(16'hABCD));

    w1 = 0; w15 = 0; run1 = 1'b1; run15 = 1'b1; st1_c1 = '0;
    Mem_Read = 1'b1; Mem_Data_In = 16'h1111;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      cycle();
      if (cyc == 1) st1_c1 = {ce1, oe1, we1};
      if (run1)  begin if (!ce1)  w1++;  else run1  = 1'b0; end
      if (run15) begin if (!ce15) w15++; else run15 = 1'b0; end
      if (rdy1)  r1.push_back(cyc);
      if (rdy15) r15.push_back(cyc);
    end
    Mem_Read = 1'b0;

    chk("ws1_strobes_c1", 80'(st1_c1), 80'(3'b001));
    chk("ws1_width", 80'(w1), 80'(1));
    chk("ws15_width", 80'(w15), 80'(15));
    chk("ws1_ready_cnt", 80'(r1.size()), 80'(13));
    chk("ws1_first_ready", 80'(r1.size() > 0 ? r1[0] : -1), 80'(2));
    chk("ws1_spacing", 80'(r1.size() > 1 ? r1[1] - r1[0] : 0), 80'(3));
    chk("ws15_ready_cnt", 80'(r15.size()), 80'(2));
    chk("ws15_first_ready", 80'(r15.size() > 0 ? r15[0] : -1), 80'(16));
    chk("ws15_spacing", 80'(r15.size() > 1 ? r15[1] - r15[0] : 0), 80'(17));
    chk("ws1_addr", 80'(addr1), 80'(20'h0ABCD));
    chk("ws15_mdr", 80'(mdr15), 80'(16'h1111));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_controller_wait.md
Name: memory_controller_wait

Overview:
- Parametrised successor to the MAR/MDR memory interface of the SLC3 datapath.
- Keeps bus-loadable MAR/MDR with the MIO.EN input mux.
- Adds a read/write handshake FSM toward synchronous SRAM with a configurable number of wait states, latched access address and write data, and a Ready (LC-3 "R") completion pulse for the control unit.
- Sits between the datapath bus/control unit and the external memory pins.

Parameters:
- DATA_W, 16, width of bus, MDR and memory data.
- ADDR_W, 16, width of MAR and memory address.
- WAIT_STATES, 2, cycles the memory strobes are held per access; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset_n  in  1  synchronous active-low reset.
- LD_MAR  in  1  load MAR from bus.
- LD_MDR  in  1  load MDR from MIO.EN mux.
- MIO_EN  in  1  MDR mux select: 1 = Mem_Data_In, 0 = bus.
- Mem_Read  in  1  start read request (level, sampled in IDLE).
- Mem_Write  in  1  start write request (level, sampled in IDLE).
- bus  in  DATA_W  datapath bus.
- Mem_Data_In  in  DATA_W  read data from memory.
- MAR  out  ADDR_W  memory address register.
- MDR  out  DATA_W  memory data register.
- Mem_Addr  out  ADDR_W  latched access address to memory.
- Mem_Data_Out  out  DATA_W  latched write data to memory.
- Mem_CE_n  out  1  chip enable, active low.
- Mem_OE_n  out  1  output enable, active low.
- Mem_WE_n  out  1  write enable, active low.
- Ready  out  1  one-cycle access-complete pulse.
- Busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset (Reset_n=0 at posedge):
  - MAR, MDR, Mem_Addr, Mem_Data_Out = 0.
  - Mem_CE_n, Mem_OE_n, Mem_WE_n = 1; Ready = 0; Busy = 0; FSM = IDLE; wait counter = 0.
  - Reset mid-access aborts the access and deasserts strobes from the next cycle; MDR is not updated by the aborted read.
- MAR load:
  - LD_MAR=1: MAR <= bus at posedge, in any FSM state.
  - Width rule: ADDR_W<DATA_W keeps bus[ADDR_W-1:0]; ADDR_W>DATA_W zero-extends.
- MDR load:
  - LD_MDR=1 in IDLE: MDR <= (MIO_EN ? Mem_Data_In : bus).
  - LD_MDR is ignored in RD, WR and DONE; MDR is owned by the FSM during an access.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - Mem_Read=1: capture Mem_Addr <= MAR, counter <= WAIT_STATES-1, go to RD.
  - Else Mem_Write=1: capture Mem_Addr <= MAR and Mem_Data_Out <= MDR, counter <= WAIT_STATES-1, go to WR.
  - Mem_Read and Mem_Write both high: read wins; the write is dropped.
  - Same-cycle LD_MAR or LD_MDR with a request: the capture uses the pre-edge MAR/MDR values.
- RD:
  - Mem_CE_n=0, Mem_OE_n=0, Mem_WE_n=1.
  - Counter decrements each cycle.
  - When counter==0: MDR <= Mem_Data_In at that posedge, go to DONE.
- WR:
  - Mem_CE_n=0, Mem_WE_n=0, Mem_OE_n=1.
  - When counter==0: go to DONE.
- DONE:
  - Ready=1, all strobes high, then go to IDLE unconditionally.
  - Requests in RD, WR or DONE are ignored and must be re-presented in IDLE.
- Strobes, Ready and Busy are registered outputs decoded from state, with no combinational path from inputs.
- Latency:
  - A request sampled at edge E0 gives strobes low for exactly WAIT_STATES cycles.
  - Ready is high in cycle WAIT_STATES+1 after E0.
  - Minimum request-to-request spacing is WAIT_STATES+2 cycles.
- Mem_Addr and Mem_Data_Out hold their values outside accesses.
- LD_MAR during an access changes MAR but never Mem_Addr.
- Busy=1 in RD, WR and DONE.

Test Plan:
- Reset then idle: hold Reset_n=0 for 2 cycles, then release -> MAR=MDR=0, strobes=1, Ready=0, Busy=0.
- Read, WAIT_STATES=2: bus=16'h3000 with LD_MAR, then Mem_Read=1 for one cycle with Mem_Data_In=16'hBEEF -> Mem_CE_n/Mem_OE_n low for exactly 2 cycles, Mem_Addr=16'h3000, MDR=16'hBEEF and Ready=1 in the 3rd cycle after the request edge, then back to IDLE.
- Write: MAR=16'h4001, MDR=16'h1234 loaded via bus, then Mem_Write=1 -> Mem_WE_n low for 2 cycles with Mem_Data_Out=16'h1234 and Mem_Addr=16'h4001; Mem_OE_n stays high; one Ready pulse.
- Simultaneous and ignored requests: Mem_Read=Mem_Write=1 in IDLE -> read performed, no WE_n pulse. Mem_Write asserted during RD -> ignored. LD_MAR=16'h5555 during RD -> MAR=16'h5555, Mem_Addr unchanged. LD_MDR during RD -> MDR unchanged until the read completes.
- Reset mid-access: assert Reset_n=0 in the 1st RD cycle -> strobes high next cycle, MDR=0, no Ready pulse.
- Parameter sweep: WAIT_STATES=1 and 15, DATA_W=16, ADDR_W=20 with bus=16'hABCD -> MAR=20'h0ABCD; strobe widths of 1 and 15 cycles; back-to-back reads spaced 3 and 17 cycles apart.
